// File: rtl/pc_stage_vec_if.sv
// EX-stage / CSR bundle consumed by the PC stage: redirect requests, trap
// requests and the CSR values that steer the next-PC choice.
interface pc_stage_vec_if;
  logic        csr_rmie;
  logic        csr_mtvec_mode;
  logic [31:2] csr_mtvec_ex;
  logic [31:2] csr_mepc_ex;
  logic        g_exception;
  logic [3:0]  exc_cause;
  logic        ecall_condition_ex;
  logic        cmd_ecall_ex;
  logic        cmd_ebreak_ex;
  logic        cmd_mret_ex;
  logic        jmp_condition_ex;
  logic [31:2] jmp_adr_ex;

  modport master (
    output csr_rmie, csr_mtvec_mode, csr_mtvec_ex, csr_mepc_ex,
           g_exception, exc_cause, ecall_condition_ex,
           cmd_ecall_ex, cmd_ebreak_ex, cmd_mret_ex,
           jmp_condition_ex, jmp_adr_ex
  );

  modport slave (
    input  csr_rmie, csr_mtvec_mode, csr_mtvec_ex, csr_mepc_ex,
           g_exception, exc_cause, ecall_condition_ex,
           cmd_ecall_ex, cmd_ebreak_ex, cmd_mret_ex,
           jmp_condition_ex, jmp_adr_ex
  );
endinterface

// File: rtl/pc_stage_vec.sv
// Program-counter stage with NIRQ edge-detected interrupt channels,
// fixed-priority arbitration and direct/vectored trap targeting.
module pc_stage_vec #(
  parameter int unsigned NIRQ       = 4,
  parameter int unsigned CAUSE_BASE = 16,
  parameter logic [31:2] RESET_PC   = 30'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_start,
  input  logic [31:2]       cpu_start_adr,
  input  logic              cpu_stat_pc,
  input  logic [NIRQ-1:0]   irq_in,
  input  logic [NIRQ-1:0]   irq_en,
  pc_stage_vec_if.slave     ex,
  output logic [31:2]       pc,
  output logic [31:2]       pc_excep,
  output logic [31:2]       pc_ebreak,
  output logic [NIRQ-1:0]   irq_pend,
  output logic              trap_take,
  output logic              trap_is_irq,
  output logic [5:0]        trap_cause,
  output logic              cmd_ecall_pc,
  output logic              cmd_ebreak_pc
);

  logic [31:2]     pc_q, pc_d;
  logic [NIRQ-1:0] irq_pend_q, irq_pend_d;
  logic [NIRQ-1:0] irq_prev_q;
  logic            adr_ld_q, adr_ld_d;
  logic            ecall_q, ecall_d;
  logic            ebreak_q, ebreak_d;

  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] pend_en;
  logic [NIRQ-1:0] grant_oh;
  logic [5:0]      irq_cause;
  logic            grant_found;
  logic            irq_req;
  logic            take_exc, take_irq, take_ecall;
  logic [31:2]     pc_inc;
  logic [31:2]     irq_target;

  assign rise    = irq_in & ~irq_prev_q;
  assign pend_en = irq_pend_q & irq_en;
  assign irq_req = (|pend_en) & ex.csr_rmie;
  assign pc_inc  = pc_q + 30'd1;

  // Lowest enabled pending channel wins.
  always_comb begin
    grant_oh    = '0;
    irq_cause   = '0;
    grant_found = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (pend_en[i] && !grant_found) begin
        grant_found = 1'b1;
        grant_oh[i] = 1'b1;
        irq_cause   = 6'(CAUSE_BASE + i);
      end
    end
  end

  assign irq_target = ex.csr_mtvec_mode ? (ex.csr_mtvec_ex + 30'(irq_cause))
                                        : ex.csr_mtvec_ex;

  // Trap classes follow the next-PC priority; a pending start load masks all.
  assign take_exc   = cpu_stat_pc & ~adr_ld_q & ex.g_exception;
  assign take_irq   = cpu_stat_pc & ~adr_ld_q & ~ex.g_exception & irq_req;
  assign take_ecall = cpu_stat_pc & ~adr_ld_q & ~ex.g_exception & ~irq_req
                    & ex.ecall_condition_ex;

  always_comb begin
    pc_d = pc_q;
    if (cpu_stat_pc) begin
      if (adr_ld_q)                   pc_d = cpu_start_adr;
      else if (ex.g_exception)        pc_d = ex.csr_mtvec_ex;
      else if (irq_req)               pc_d = irq_target;
      else if (ex.ecall_condition_ex) pc_d = ex.csr_mtvec_ex;
      else if (ex.cmd_mret_ex)        pc_d = ex.csr_mepc_ex;
      else if (ex.jmp_condition_ex)   pc_d = ex.jmp_adr_ex;
      else                            pc_d = pc_inc;
    end
  end

  // A fresh enabled edge re-arms a channel even as it is being taken.
  assign irq_pend_d = (irq_pend_q & ~({NIRQ{take_irq}} & grant_oh)) | (rise & irq_en);

  assign adr_ld_d = cpu_stat_pc ? 1'b0 : (adr_ld_q | cpu_start);
  assign ecall_d  = cpu_stat_pc ? 1'b0 : (ecall_q  | ex.cmd_ecall_ex);
  assign ebreak_d = cpu_stat_pc ? 1'b0 : (ebreak_q | ex.cmd_ebreak_ex);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      irq_pend_q <= '0;
      irq_prev_q <= '0;
      adr_ld_q   <= 1'b0;
      ecall_q    <= 1'b0;
      ebreak_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      irq_pend_q <= irq_pend_d;
      irq_prev_q <= irq_in;
      adr_ld_q   <= adr_ld_d;
      ecall_q    <= ecall_d;
      ebreak_q   <= ebreak_d;
    end
  end

  always_comb begin
    trap_cause = '0;
    if (take_exc)        trap_cause = {2'b00, ex.exc_cause};
    else if (take_irq)   trap_cause = irq_cause;
    else if (take_ecall) trap_cause = ebreak_q ? 6'd3 : 6'd11;
  end

  assign trap_take     = take_exc | take_irq | take_ecall;
  assign trap_is_irq   = take_irq;

  assign pc            = pc_q;
  assign pc_ebreak     = pc_q;
  assign irq_pend      = irq_pend_q;
  assign pc_excep      = ex.g_exception      ? pc_q :
                         ex.jmp_condition_ex ? ex.jmp_adr_ex : pc_inc;

  assign cmd_ecall_pc  = cpu_stat_pc & ecall_q  & ~irq_req & ex.csr_rmie;
  assign cmd_ebreak_pc = cpu_stat_pc & ebreak_q & ~irq_req & ex.csr_rmie;

endmodule

// File: tb/tb_pc_stage_vec.sv
// Directed, table-driven bench for pc_stage_vec (NIRQ=4, CAUSE_BASE=16).
module tb_pc_stage_vec;

  logic        clk;
  logic        rst_n;
  logic        cpu_start;
  logic [31:2] cpu_start_adr;
  logic        cpu_stat_pc;
  logic [3:0]  irq_in;
  logic [3:0]  irq_en;
  logic [31:2] pc, pc_excep, pc_ebreak;
  logic [3:0]  irq_pend;
  logic        trap_take, trap_is_irq;
  logic [5:0]  trap_cause;
  logic        cmd_ecall_pc, cmd_ebreak_pc;

  pc_stage_vec_if bus ();

  pc_stage_vec #(
    .NIRQ       (4),
    .CAUSE_BASE (16),
    .RESET_PC   (30'd0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_start     (cpu_start),
    .cpu_start_adr (cpu_start_adr),
    .cpu_stat_pc   (cpu_stat_pc),
    .irq_in        (irq_in),
    .irq_en        (irq_en),
    .ex            (bus),
    .pc            (pc),
    .pc_excep      (pc_excep),
    .pc_ebreak     (pc_ebreak),
    .irq_pend      (irq_pend),
    .trap_take     (trap_take),
    .trap_is_irq   (trap_is_irq),
    .trap_cause    (trap_cause),
    .cmd_ecall_pc  (cmd_ecall_pc),
    .cmd_ebreak_pc (cmd_ebreak_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stat;
    logic        start;
    logic [29:0] adr;
    logic        rmie;
    logic        mode;
    logic [3:0]  irq;
    logic [3:0]  en;
    logic        exc;
    logic [3:0]  ecause;
    logic        ecall;
    logic        ebrk;
    logic        mret;
    logic        jmp;
    logic [29:0] jadr;
    logic        e_take;
    logic [5:0]  e_cause;
    logic        e_isirq;
    logic [29:0] e_pc;
    logic [3:0]  e_pend;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic stat, input logic start, input logic [29:0] adr,
    input logic rmie, input logic mode, input logic [3:0] irq, input logic [3:0] en,
    input logic exc, input logic [3:0] ecause, input logic ecall, input logic ebrk,
    input logic mret, input logic jmp, input logic [29:0] jadr,
    input logic take, input logic [5:0] cause, input logic isirq,
    input logic [29:0] epc, input logic [3:0] pend);
    vec_t v;
    v.stat = stat;   v.start = start; v.adr = adr;     v.rmie = rmie;
    v.mode = mode;   v.irq = irq;     v.en = en;       v.exc = exc;
    v.ecause = ecause; v.ecall = ecall; v.ebrk = ebrk; v.mret = mret;
    v.jmp = jmp;     v.jadr = jadr;   v.e_take = take; v.e_cause = cause;
    v.e_isirq = isirq; v.e_pc = epc;  v.e_pend = pend;
    return v;
  endfunction

  initial begin
    //              st sr adr   rm md irq en  ex ec ca eb mr jp jadr   tk cause ii pc     pend
    tbl[0]  = mk(0, 1, 'h100, 1, 1, 0, 'hF, 0, 0, 0, 0, 0, 0, 0,     0, 0,  0, 'h000, 'h0);
    tbl[1]  = mk(1, 0, 'h100, 1, 1, 0, 'hF, 0, 0, 0, 0, 0, 0, 0,     0, 0,  0, 'h100, 'h0);
    tbl[2]  = mk(1, 0, 0,     1, 1, 0, 'hF, 0, 0, 0, 0, 0, 0, 0,     0, 0,  0, 'h101, 'h0);
    tbl[3]  = mk(1, 0, 0,     1, 1, 0, 'hF, 0, 0, 0, 0, 0, 0, 0,     0, 0,  0, 'h102, 'h0);
    tbl[4]  = mk(0, 0, 0,     1, 1, 4, 'hF, 0, 0, 0, 0, 0, 0, 0,     0, 0,  0, 'h102, 'h4);
    tbl[5]  = mk(1, 0, 0,     1, 1, 4, 'hF, 0, 0, 0, 0, 0, 0, 0,     1, 18, 1, 'h052, 'h0);
    tbl[6]  = mk(0, 0, 0,     1, 1, 'hA, 'hF, 0, 0, 0, 0, 0, 0, 0,   0, 0,  0, 'h052, 'hA);
    tbl[7]  = mk(1, 0, 0,     1, 1, 'hA, 'hF, 0, 0, 0, 0, 0, 0, 0,   1, 17, 1, 'h051, 'h8);
    tbl[8]  = mk(1, 0, 0,     1, 1, 0, 'hF, 0, 0, 0, 0, 0, 0, 0,     1, 19, 1, 'h053, 'h0);
    tbl[9]  = mk(0, 0, 0,     1, 1, 1, 'hF, 0, 0, 0, 0, 0, 0, 0,     0, 0,  0, 'h053, 'h1);
    tbl[10] = mk(1, 0, 0,     1, 1, 1, 'hF, 1, 2, 0, 0, 0, 0, 0,     1, 2,  0, 'h040, 'h1);
    tbl[11] = mk(1, 0, 0,     0, 1, 0, 'hF, 0, 0, 0, 0, 0, 1, 'h200, 0, 0,  0, 'h200, 'h1);
    tbl[12] = mk(1, 0, 0,     1, 1, 0, 'hF, 0, 0, 0, 0, 0, 0, 0,     1, 16, 1, 'h050, 'h0);
    tbl[13] = mk(0, 0, 0,     1, 0, 1, 'hF, 0, 0, 0, 0, 0, 0, 0,     0, 0,  0, 'h050, 'h1);
    tbl[14] = mk(1, 0, 0,     1, 0, 0, 'hF, 0, 0, 0, 0, 0, 0, 0,     1, 16, 1, 'h040, 'h0);
    tbl[15] = mk(1, 0, 0,     1, 1, 0, 'hF, 0, 0, 1, 0, 0, 0, 0,     1, 11, 0, 'h040, 'h0);
    tbl[16] = mk(0, 0, 0,     1, 1, 0, 'hF, 0, 0, 0, 1, 0, 0, 0,     0, 0,  0, 'h040, 'h0);
    tbl[17] = mk(1, 0, 0,     1, 1, 0, 'hF, 0, 0, 1, 0, 0, 0, 0,     1, 3,  0, 'h040, 'h0);
    tbl[18] = mk(1, 0, 0,     1, 1, 0, 'hF, 0, 0, 0, 0, 1, 0, 0,     0, 0,  0, 'h300, 'h0);
    tbl[19] = mk(1, 0, 0,     1, 1, 0, 'hF, 0, 0, 0, 0, 0, 0, 0,     0, 0,  0, 'h301, 'h0);
    tbl[20] = mk(0, 0, 0,     1, 1, 1, 'hF, 0, 0, 0, 0, 0, 0, 0,     0, 0,  0, 'h301, 'h1);
    tbl[21] = mk(0, 0, 0,     1, 1, 0, 'hF, 0, 0, 0, 0, 0, 0, 0,     0, 0,  0, 'h301, 'h1);
    tbl[22] = mk(1, 0, 0,     1, 1, 1, 'hF, 0, 0, 0, 0, 0, 0, 0,     1, 16, 1, 'h050, 'h1);
    tbl[23] = mk(1, 0, 0,     1, 1, 9, 'h6, 0, 0, 0, 0, 0, 0, 0,     0, 0,  0, 'h051, 'h1);
    tbl[24] = mk(1, 0, 0,     1, 1, 0, 'hF, 0, 0, 0, 0, 0, 0, 0,     1, 16, 1, 'h050, 'h0);

    rst_n                  = 1'b1;
    cpu_start              = 1'b0;
    cpu_start_adr          = '0;
    cpu_stat_pc            = 1'b0;
    irq_in                 = '0;
    irq_en                 = '0;
    bus.csr_rmie           = 1'b0;
    bus.csr_mtvec_mode     = 1'b0;
    bus.csr_mtvec_ex       = 30'h40;
    bus.csr_mepc_ex        = 30'h300;
    bus.g_exception        = 1'b0;
    bus.exc_cause          = '0;
    bus.ecall_condition_ex = 1'b0;
    bus.cmd_ecall_ex       = 1'b0;
    bus.cmd_ebreak_ex      = 1'b0;
    bus.cmd_mret_ex        = 1'b0;
    bus.jmp_condition_ex   = 1'b0;
    bus.jmp_adr_ex         = '0;

    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pc",        32'(pc),            32'h0);
    chk("rst_pend",      32'(irq_pend),      32'h0);
    chk("rst_take",      32'(trap_take),     32'h0);
    chk("rst_cause",     32'(trap_cause),    32'h0);
    chk("rst_isirq",     32'(trap_is_irq),   32'h0);
    chk("rst_pc_excep",  32'(pc_excep),      32'h1);
    chk("rst_pc_ebreak", 32'(pc_ebreak),     32'h0);
    chk("rst_ecall_pc",  32'(cmd_ecall_pc),  32'h0);
    chk("rst_ebreak_pc", 32'(cmd_ebreak_pc), 32'h0);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      cpu_stat_pc            = tbl[k].stat;
      cpu_start              = tbl[k].start;
      cpu_start_adr          = tbl[k].adr;
      bus.csr_rmie           = tbl[k].rmie;
      bus.csr_mtvec_mode     = tbl[k].mode;
      irq_in                 = tbl[k].irq;
      irq_en                 = tbl[k].en;
      bus.g_exception        = tbl[k].exc;
      bus.exc_cause          = tbl[k].ecause;
      bus.ecall_condition_ex = tbl[k].ecall;
      bus.cmd_ebreak_ex      = tbl[k].ebrk;
      bus.cmd_mret_ex        = tbl[k].mret;
      bus.jmp_condition_ex   = tbl[k].jmp;
      bus.jmp_adr_ex         = tbl[k].jadr;
      #3;
      chk($sformatf("v%0d_take", k),  32'(trap_take),   32'(tbl[k].e_take));
      chk($sformatf("v%0d_cause", k), 32'(trap_cause),  32'(tbl[k].e_cause));
      chk($sformatf("v%0d_isirq", k), 32'(trap_is_irq), 32'(tbl[k].e_isirq));
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", k),    32'(pc),          32'(tbl[k].e_pc));
      chk($sformatf("v%0d_pend", k),  32'(irq_pend),    32'(tbl[k].e_pend));
    end

    // Ecall keeper presented at the next advance; pc_excep selection.
    cpu_stat_pc = 1'b0; irq_in = '0; irq_en = 4'hF; bus.csr_rmie = 1'b1;
    bus.cmd_ebreak_ex = 1'b0; bus.cmd_ecall_ex = 1'b1;
    @(posedge clk); #1;
    bus.cmd_ecall_ex = 1'b0; cpu_stat_pc = 1'b1;
    bus.jmp_condition_ex = 1'b1; bus.jmp_adr_ex = 30'h123;
    #3;
    chk("ecall_pc",      32'(cmd_ecall_pc),  32'h1);
    chk("ebreak_pc",     32'(cmd_ebreak_pc), 32'h0);
    chk("excep_jmp",     32'(pc_excep),      32'h123);
    chk("ecall_no_trap", 32'(trap_take),     32'h0);
    @(posedge clk); #1;
    chk("jmp_pc", 32'(pc), 32'h123);
    cpu_stat_pc = 1'b0; bus.jmp_condition_ex = 1'b0;
    #1;
    chk("ecall_cleared", 32'(cmd_ecall_pc), 32'h0);
    chk("excep_seq",     32'(pc_excep),     32'h124);
    chk("pc_ebreak",     32'(pc_ebreak),    32'h123);
    bus.g_exception = 1'b1;
    #1;
    chk("excep_exc", 32'(pc_excep), 32'h123);
    bus.g_exception = 1'b0;

    // Asynchronous reset mid-run, then a fresh start.
    irq_in = 4'h1;
    @(posedge clk); #1;
    chk("pre_rst_pend", 32'(irq_pend), 32'h1);
    #2;
    rst_n = 1'b0; irq_in = '0;
    #1;
    chk("async_rst_pc",   32'(pc),       32'h0);
    chk("async_rst_pend", 32'(irq_pend), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; cpu_stat_pc = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_pc", 32'(pc), 32'h1);
    cpu_stat_pc = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_stage_vec.md
# pc_stage_vec

Parametrised program-counter stage with per-channel interrupt pending latches, fixed-priority arbitration, RISC-V vectored/direct trap targeting and trap-cause generation. It sits at the head of the pipeline. On every `cpu_stat_pc` advance it selects the next PC from one of: start address, trap vector, `mret` return, EX-stage branch/jump, or sequential increment. It replaces the single-interrupt PC stage by supporting NIRQ independently enabled, edge-detected channels that are cleared individually only when taken.

## Interface
- NIRQ, 4, number of interrupt channels (1..16)
- CAUSE_BASE, 16, cause code of channel 0; channel i reports CAUSE_BASE+i (6-bit result, must not exceed 63)
- RESET_PC, 30'd0, `pc` value after reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_start  in  1  request load of `cpu_start_adr` at next advance
- cpu_start_adr  in  [31:2]  start word address
- cpu_stat_pc  in  1  PC advance enable (one cycle per instruction slot)
- csr_rmie  in  1  global machine interrupt enable
- csr_mtvec_mode  in  1  0 direct, 1 vectored
- csr_mtvec_ex  in  [31:2]  trap base word address
- csr_mepc_ex  in  [31:2]  `mret` return word address
- irq_in  in  [NIRQ-1:0]  interrupt request levels
- irq_en  in  [NIRQ-1:0]  per-channel enables (`mie` bits)
- g_exception  in  1  synchronous exception from EX
- exc_cause  in  [3:0]  cause code accompanying `g_exception`
- ecall_condition_ex  in  1  EX ecall/ebreak trap request
- cmd_ecall_ex, cmd_ebreak_ex  in  1  EX-stage ecall / ebreak decode
- cmd_mret_ex  in  1  EX-stage `mret`
- jmp_condition_ex  in  1  EX branch/jump taken
- jmp_adr_ex  in  [31:2]  branch/jump target
- pc  out  [31:2]  current PC register
- pc_excep  out  [31:2]  value to write into mepc
- pc_ebreak  out  [31:2]  equals `pc`
- irq_pend  out  [NIRQ-1:0]  pending latches (registered)
- trap_take  out  1  trap accepted this cycle (combinational)
- trap_is_irq  out  1  accepted trap is an interrupt
- trap_cause  out  [5:0]  cause code, valid with `trap_take`
- cmd_ecall_pc, cmd_ebreak_pc  out  1  held ecall/ebreak presented at PC advance

## Operation
- Start latch `adr_ld`: set by `cpu_start`, cleared on `cpu_stat_pc`; clear wins over set.
- Edge detect: `irq_prev <= irq_in` every cycle. `rise[i] = irq_in[i] & ~irq_prev[i]`.
- Pending: `irq_pend[i]` is set when `rise[i] & irq_en[i]`. It is cleared only when channel i is the taken interrupt. Set wins over clear in the same cycle.
- `irq_req = |(irq_pend & irq_en) & csr_rmie`. Granted channel is the lowest index with `pend & en`.
- Ecall/ebreak keepers: set by `cmd_ecall_ex` / `cmd_ebreak_ex`, cleared on `cpu_stat_pc` (clear wins).
  - `cmd_ecall_pc = cpu_stat_pc & keeper & ~irq_req & csr_rmie`; `cmd_ebreak_pc` is defined the same way.
- Next-PC priority when `cpu_stat_pc` is high (first match wins):
  1. `adr_ld` → `cpu_start_adr`, no trap.
  2. `g_exception` → `csr_mtvec_ex`, cause `{2'b0,exc_cause}`, trap_is_irq 0.
  3. `irq_req` → direct: `csr_mtvec_ex`; vectored: `csr_mtvec_ex + cause`. Cause is CAUSE_BASE+granted index; trap_is_irq 1; the granted pend bit is cleared.
  4. `ecall_condition_ex` → `csr_mtvec_ex`, cause 3 if the ebreak keeper is set, else 11.
  5. `cmd_mret_ex` → `csr_mepc_ex`.
  6. `jmp_condition_ex` → `jmp_adr_ex`.
  7. otherwise `pc+1`.
- `trap_take = cpu_stat_pc & ~adr_ld & (g_exception | irq_req | ecall_condition_ex)`.
- `trap_cause` / `trap_is_irq` are 0 when `trap_take` is low.
- `pc_excep = g_exception ? pc : jmp_condition_ex ? jmp_adr_ex : pc+1`.
- Vector addition: 30-bit modulo; wrap at 2^30 is silent.
- When `cpu_stat_pc` is low, `pc` holds and no pend bit clears.

## Timing
- Reset values:
  - `pc` = RESET_PC; `irq_pend`, `irq_prev`, `adr_ld` and both keepers = 0.
  - All combinational outputs are 0 except `pc_excep` = RESET_PC+1 and `pc_ebreak` = RESET_PC.
- Edge-to-pending: the `irq_in` rise at edge N gives `irq_pend` at edge N+1. The earliest interrupt redirect is the first `cpu_stat_pc` cycle after that.
- The PC update lands on the edge that closes the `cpu_stat_pc` cycle: 1-cycle latency.
- A level held high produces only one pend. A re-assert needs a low cycle first.
- Disabled edges are lost: clearing `irq_en[i]` later masks `irq_req` but keeps the pend bit.
- `rst_n` low mid-operation returns every register to its reset value immediately. The first edge after release behaves like a fresh start.

## Test plan
- Start: reset, `cpu_start`, then `cpu_start_adr`=0x100 with 3 `cpu_stat_pc` pulses → `pc` = 0x100, 0x101, 0x102.
- Vectored IRQ: NIRQ=4, rmie=1, mode=1, mtvec=0x40, pulse `irq_in[2]` → `trap_take`=1, `trap_cause`=18, `pc`=0x52, `irq_pend[2]` clears, others untouched.
- Priority: `irq_pend[1]` and `irq_pend[3]` set → first advance takes cause 17, second advance takes cause 19.
- Exception beats IRQ: `g_exception`, `exc_cause`=2 and `irq_pend[0]` all set → `pc`=0x40, cause 2, `irq_pend[0]` stays 1.
- Masking: rmie=0 with `irq_pend[0]`=1 and `jmp_condition_ex`, `jmp_adr_ex`=0x200 → `pc`=0x200, `trap_take`=0. Set rmie=1 → next advance traps.
- Simultaneous set/clear: second rise on `irq_in[0]` in the same cycle channel 0 is taken → `irq_pend[0]` remains 1. Assert `rst_n` low mid-run → `pc`=RESET_PC and `irq_pend`=0 immediately.
